pingpong_serializer: RTL and testbench

- Parametrised double-buffered (ping-pong) capture/serialiser between a wide parallel layer output and an element-serial consumer, e.g. the pooling output that feeds a fully-connected layer.
- Captures a whole N-element vector in one cycle and streams it out one element per accepted beat with an index.
- Adds explicit two-bank full tracking, consumer back-pressure, producer-side ready, overflow detection and back-to-back frame streaming with no bubble.

---
 rtl/pingpong_serializer_pkg.sv | 17 +
 rtl/pingpong_serializer_if.sv | 31 +++
 rtl/pingpong_serializer_bank_regs.sv | 36 +++
 rtl/pingpong_serializer.sv | 132 +++++++++++++
 tb/tb_pingpong_serializer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pingpong_serializer_pkg.sv
// Shared constants, read-FSM state type and index-width helper for the
// ping-pong frame serialiser.
package pingpong_serializer_pkg;

    localparam int unsigned L4_DW = 16;
    localparam int unsigned L4_N  = 84;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } rd_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pingpong_serializer_if.sv
// Frame-in / element-stream-out bus of the ping-pong serialiser.
interface pingpong_serializer_if
    import pingpong_serializer_pkg::*;
#(
    parameter int unsigned DW = L4_DW,
    parameter int unsigned N  = L4_N,
    parameter int unsigned AW = idx_width(N)
) ();

    logic [N*DW-1:0] din;
    logic            save;
    logic            save_ready;
    logic [DW-1:0]   dout;
    logic [AW-1:0]   addr;
    logic            dout_valid;
    logic            dout_ready;
    logic            dout_last;
    logic            overflow;
    logic            ovf_clr;

    modport master (
        output din, save, dout_ready, ovf_clr,
        input  save_ready, dout, addr, dout_valid, dout_last, overflow
    );

    modport slave (
        input  din, save, dout_ready, ovf_clr,
        output save_ready, dout, addr, dout_valid, dout_last, overflow
    );

endinterface

// File: rtl/pingpong_serializer_bank_regs.sv
// Two banks of N elements: whole-frame parallel write, element-indexed read.
module pp_bank_regs
    import pingpong_serializer_pkg::*;
#(
    parameter int unsigned DW = L4_DW,
    parameter int unsigned N  = L4_N,
    parameter int unsigned AW = idx_width(N)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic            wr_bank_i,
    input  logic [N*DW-1:0] wdata_i,
    input  logic            rd_bank_i,
    input  logic [AW-1:0]   rd_idx_i,
    output logic [DW-1:0]   rd_data_o
);

    logic [DW-1:0] mem_q [2][N];

    // Element 0 lives in the MSBs of the frame word; contents are never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                mem_q[wr_bank_i][k] <= wdata_i[(N-k)*DW-1 -: DW];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (32'(rd_idx_i) < N) begin
            rd_data_o = mem_q[rd_bank_i][rd_idx_i];
        end
    end

endmodule

// File: rtl/pingpong_serializer.sv
// Double-buffered frame capture with element-serial, back-pressured readout
// and gap-free streaming across consecutive frames.
module pingpong_serializer
    import pingpong_serializer_pkg::*;
#(
    parameter int unsigned DW = L4_DW,
    parameter int unsigned N  = L4_N,
    parameter int unsigned AW = idx_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    pingpong_serializer_if.slave bus
);

    rd_state_e     state_q;
    logic [1:0]    full_q, full_d;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] dout_q;
    logic [AW-1:0] addr_q;
    logic          valid_q;

    logic          save_ready_c;
    logic          wr_c;
    logic          accept_c;
    logic          last_c;
    logic          release_c;
    logic          rd_bank_c;
    logic [AW-1:0] rd_idx_c;
    logic [DW-1:0] rd_data;

    pp_bank_regs #(.DW(DW), .N(N), .AW(AW)) u_banks (
        .clk       (clk),
        .we_i      (wr_c),
        .wr_bank_i (wptr_q),
        .wdata_i   (bus.din),
        .rd_bank_i (rd_bank_c),
        .rd_idx_i  (rd_idx_c),
        .rd_data_o (rd_data)
    );

    // Flag updates use pre-edge state, so a bank being released is not writable this cycle.
    always_comb begin
        save_ready_c = ~full_q[wptr_q];
        wr_c         = bus.save && save_ready_c;
        accept_c     = valid_q && bus.dout_ready;
        last_c       = (addr_q == AW'(N - 1));
        release_c    = (state_q == ST_STREAM) && accept_c && last_c;

        full_d = full_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_c) begin
            full_d[wptr_q] = 1'b1;
            wptr_d         = ~wptr_q;
        end
        if (release_c) begin
            full_d[rptr_q] = 1'b0;
            rptr_d         = ~rptr_q;
        end

        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.save && !save_ready_c) begin
            ovf_d = 1'b1;
        end

        // Read address for whatever the FSM will load at the next edge.
        rd_bank_c = rptr_q;
        rd_idx_c  = '0;
        if (state_q == ST_STREAM) begin
            if (release_c) begin
                rd_bank_c = ~rptr_q;
            end else begin
                rd_idx_c = addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            full_q  <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dout_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            full_q <= full_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rptr_q]) begin
                        dout_q  <= rd_data;
                        addr_q  <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept_c) begin
                        if (!last_c) begin
                            addr_q <= addr_q + AW'(1);
                            dout_q <= rd_data;
                        end else if (full_q[~rptr_q]) begin
                            dout_q <= rd_data;
                            addr_q <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.save_ready = save_ready_c;
    assign bus.dout       = dout_q;
    assign bus.addr       = addr_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_last  = valid_q && last_c;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_pingpong_serializer.sv
// Directed bench for pingpong_serializer: per-cycle vector table plus
// streaming sequences checked against a queue of expected beats.
module tb_pingpong_serializer;
    import pingpong_serializer_pkg::*;

    localparam int unsigned DW = L4_DW;
    localparam int unsigned N  = L4_N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pingpong_serializer_if #(.DW(DW), .N(N)) bus ();

    pingpong_serializer #(.DW(DW), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int val;
        int addr;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        bit save;
        int fsel;
        bit ready;
        bit clr;
        int exp_sr;
        int exp_valid;
        int exp_addr;
        int exp_dout;
        int exp_ovf;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dout_i();
        return int'($signed(bus.dout));
    endfunction

    function automatic logic [N*DW-1:0] mk_frame(input int base);
        logic [N*DW-1:0] f;
        f = '0;
        for (int k = 0; k < int'(N); k++) begin
            f[(int'(N) - k)*int'(DW) - 1 -: DW] = DW'(base + k);
        end
        return f;
    endfunction

    function automatic void push_frame(input int base, input int first);
        for (int k = first; k < int'(N); k++) begin
            exp_q.push_back('{base + k, k});
        end
    endfunction

    function automatic int base_of(input int fsel);
        case (fsel)
            0:       return 0;
            1:       return 1000;
            default: return -3000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.save       = 1'b0;
        bus.dout_ready = 1'b0;
        bus.ovf_clr    = 1'b0;
        bus.din        = '0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic save_frame(input string tag, input int base);
        bus.din  = mk_frame(base);
        bus.save = 1'b1;
        check({tag, " save_ready"}, int'(bus.save_ready), 1);
        step();
        bus.save = 1'b0;
    endtask

    // Consume n beats from exp_q; optionally inject one save at loop cycle save_at.
    task automatic drain(input string tag, input int n, input int pct, input bit no_gap,
                         input int save_at, input int save_base, input int final_valid);
        int got = 0;
        int cyc = 0;
        bit started = 1'b0;
        bit have_hold = 1'b0;
        int hold_dout = 0;
        int hold_addr = 0;
        bit rdy;
        beat_t e;
        while (got < n && cyc < n * 20 + 50) begin
            rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            bus.dout_ready = rdy;
            if (cyc == save_at) begin
                bus.din  = mk_frame(save_base);
                bus.save = 1'b1;
                check({tag, " mid save_ready"}, int'(bus.save_ready), 1);
            end else begin
                bus.save = 1'b0;
            end
            if (have_hold) begin
                check({tag, " stall valid"}, int'(bus.dout_valid), 1);
                check({tag, " stall dout"}, dout_i(), hold_dout);
                check({tag, " stall addr"}, int'(bus.addr), hold_addr);
            end
            if (bus.dout_valid) begin
                started = 1'b1;
                if (rdy) begin
                    e = exp_q.pop_front();
                    check($sformatf("%s beat%0d dout", tag, got), dout_i(), e.val);
                    check($sformatf("%s beat%0d addr", tag, got), int'(bus.addr), e.addr);
                    check($sformatf("%s beat%0d last", tag, got), int'(bus.dout_last),
                          (e.addr == int'(N) - 1) ? 1 : 0);
                    got++;
                    have_hold = 1'b0;
                end else begin
                    hold_dout = dout_i();
                    hold_addr = int'(bus.addr);
                    have_hold = 1'b1;
                end
            end else if (started && no_gap) begin
                check({tag, " no gap"}, 0, 1);
            end
            step();
            cyc++;
        end
        bus.save = 1'b0;
        if (got < n) begin
            check({tag, " beats before timeout"}, got, n);
        end
        if (final_valid >= 0) begin
            check({tag, " valid after"}, int'(bus.dout_valid), final_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 0, 1'b0, 1'b0, 1, 0, 0, 0, 0};
        tbl[1] = '{1'b0, 0, 1'b0, 1'b0, 1, 1, 0, 0, 0};
        tbl[2] = '{1'b1, 1, 1'b0, 1'b0, 1, 1, 0, 0, 0};
        tbl[3] = '{1'b0, 0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
        tbl[4] = '{1'b1, 2, 1'b0, 1'b0, 0, 1, 0, 0, 1};
        tbl[5] = '{1'b0, 0, 1'b1, 1'b0, 0, 1, 1, 1, 1};
        tbl[6] = '{1'b0, 0, 1'b0, 1'b1, 0, 1, 1, 1, 0};
        tbl[7] = '{1'b1, 2, 1'b0, 1'b1, 0, 1, 1, 1, 1};
        tbl[8] = '{1'b0, 0, 1'b0, 1'b1, 0, 1, 1, 1, 0};

        // Reset state and single frame with signed payload
        do_reset();
        check("rst valid", int'(bus.dout_valid), 0);
        check("rst addr", int'(bus.addr), 0);
        check("rst dout", dout_i(), 0);
        check("rst overflow", int'(bus.overflow), 0);
        check("rst save_ready", int'(bus.save_ready), 1);
        check("rst last", int'(bus.dout_last), 0);
        save_frame("s1", -42);
        check("s1 valid t", int'(bus.dout_valid), 0);
        step();
        check("s1 valid t+1", int'(bus.dout_valid), 1);
        push_frame(-42, 0);
        drain("s1", 84, 100, 1'b1, -1, 0, 0);

        // Two frames, second saved mid-stream, no bubble at the boundary
        do_reset();
        bus.dout_ready = 1'b1;
        save_frame("s2", 0);
        push_frame(0, 0);
        push_frame(1000, 0);
        drain("s2", 168, 100, 1'b1, 2, 1000, 0);

        // Overflow table: three saves under full back-pressure, then ovf_clr
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.save       = tbl[i].save;
            bus.din        = mk_frame(base_of(tbl[i].fsel));
            bus.dout_ready = tbl[i].ready;
            bus.ovf_clr    = tbl[i].clr;
            check($sformatf("v%0d save_ready", i), int'(bus.save_ready), tbl[i].exp_sr);
            step();
            check($sformatf("v%0d valid", i), int'(bus.dout_valid), tbl[i].exp_valid);
            check($sformatf("v%0d addr", i), int'(bus.addr), tbl[i].exp_addr);
            check($sformatf("v%0d dout", i), dout_i(), tbl[i].exp_dout);
            check($sformatf("v%0d overflow", i), int'(bus.overflow), tbl[i].exp_ovf);
        end
        bus.save    = 1'b0;
        bus.ovf_clr = 1'b0;
        push_frame(0, 1);
        push_frame(1000, 0);
        drain("s3", 167, 100, 1'b1, -1, 0, 0);

        // Random back-pressure over four frames
        do_reset();
        save_frame("s4a", 3000);
        save_frame("s4b", 4000);
        push_frame(3000, 0);
        push_frame(4000, 0);
        drain("s4ab", 168, 50, 1'b0, -1, 0, 0);
        save_frame("s4c", -2000);
        save_frame("s4d", -4000);
        push_frame(-2000, 0);
        push_frame(-4000, 0);
        drain("s4cd", 168, 50, 1'b0, -1, 0, 0);

        // Save colliding with the release of bank 0 while bank 1 is full
        do_reset();
        save_frame("s5x", 100);
        save_frame("s5y", 200);
        push_frame(100, 0);
        drain("s5x", 83, 100, 1'b1, -1, 0, -1);
        check("s5 addr before last", int'(bus.addr), 83);
        check("s5 last flag", int'(bus.dout_last), 1);
        check("s5 last dout", dout_i(), 183);
        exp_q.delete();
        bus.dout_ready = 1'b1;
        bus.din        = mk_frame(300);
        bus.save       = 1'b1;
        check("s5 collide save_ready", int'(bus.save_ready), 0);
        step();
        check("s5 collide overflow", int'(bus.overflow), 1);
        check("s5 switch valid", int'(bus.dout_valid), 1);
        check("s5 switch addr", int'(bus.addr), 0);
        check("s5 switch dout", dout_i(), 200);
        check("s5 retry save_ready", int'(bus.save_ready), 1);
        bus.din        = mk_frame(300);
        bus.save       = 1'b1;
        bus.dout_ready = 1'b0;
        step();
        bus.save = 1'b0;
        check("s5 both full save_ready", int'(bus.save_ready), 0);
        push_frame(200, 0);
        push_frame(300, 0);
        drain("s5yz", 168, 100, 1'b1, -1, 0, 0);

        // Asynchronous reset mid-stream at addr 40
        save_frame("s6w", -1000);
        step();
        push_frame(-1000, 0);
        drain("s6w", 40, 100, 1'b1, -1, 0, -1);
        check("s6 addr before rst", int'(bus.addr), 40);
        #2;
        rst = 1'b1;
        #1;
        check("s6 async valid", int'(bus.dout_valid), 0);
        check("s6 async addr", int'(bus.addr), 0);
        check("s6 async dout", dout_i(), 0);
        check("s6 async overflow", int'(bus.overflow), 0);
        check("s6 async save_ready", int'(bus.save_ready), 1);
        check("s6 async last", int'(bus.dout_last), 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        save_frame("s6v", 500);
        step();
        check("s6 restart addr", int'(bus.addr), 0);
        push_frame(500, 0);
        drain("s6v", 84, 100, 1'b1, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
